multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle ARM-subset datapath. It decodes the latched instruction and sequences fetch, decode, execute, memory and writeback one state per clock. It drives every datapath mux select and write enable, including imm_src into the immediate extender. It also holds the NZCV flag register and gates all architectural writes on the condition field.

Parameters:
none (all encodings fixed in ctrl_pkg)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
cond  in  4  instr[31:28]
op  in  2  instr[27:26]
funct  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (mem)
rd  in  4  instr[15:12]
alu_flags  in  4  NZCV from ALU, current cycle
pc_write  out  1  PC register enable
ir_write  out  1  instruction register enable
reg_write  out  1  register file write enable
mem_write  out  1  data memory write enable
adr_src  out  1  0=PC, 1=ALU result as memory address
alu_src_a  out  1  0=register A, 1=PC
alu_src_b  out  2  00=register B, 01=extended imm, 10=constant 4
result_src  out  2  00=ALUOut reg, 01=read data, 10=ALU result direct
imm_src  out  2  00=8-bit zero-ext, 01=12-bit zero-ext, 10=24-bit x4
alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

Behaviour:
- Moore FSM, state register updated on rising clk.
- rst_n==0 at an edge: state<=FETCH, flags<=4'b0000.
  - This applies mid-instruction too: the partial instruction is abandoned.
  - While rst_n==0, pc_write/ir_write/reg_write/mem_write are forced 0.
- imm_src = op in every state (11 maps to 00).
- Default outputs are 0 / 00 unless listed for a state.
- FETCH: ir_write=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, alu_control=ADD, pc_write=1 -> DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10. Next state:
  - op=01 -> MEMADR
  - op=00 & funct[5]=0 -> EXECR
  - op=00 & funct[5]=1 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH (treated as NOP)
- MEMADR: alu_src_b=01, ADD -> MEMRD if funct[0]=1, else MEMWR.
- MEMRD: adr_src=1 -> MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex -> FETCH.
- MEMWR: adr_src=1, mem_write=cond_ex -> FETCH.
- EXECR: alu_src_b=00, alu_control from cmd -> ALUWB.
- EXECI: alu_src_b=01, alu_control from cmd -> ALUWB.
- ALUWB: result_src=00 -> FETCH.
  - reg_write = cond_ex & (cmd!=CMP).
  - pc_write = cond_ex & (cmd!=CMP) & (rd==15).
- BRANCH: alu_src_a=0 (R15 reads PC+8), alu_src_b=01, result_src=10, pc_write=cond_ex -> FETCH.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (alu_control=SUB).
  - Any other cmd executes as ADD.
- Flag update: in EXECR/EXECI, at the clock edge, when cond_ex & (funct[0] | cmd==CMP):
  - N,Z <= alu_flags[3:2] always.
  - C,V <= alu_flags[1:0] only for ADD/SUB/CMP; otherwise C,V are held.
  - The ALUWB of the same instruction and any later instruction see the new flags.
- cond_ex is combinational from cond and the stored flags (never alu_flags):
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - 1110 AL = 1; 1111 = 0 (never executes).
- Latency: 3 cycles for branch, 4 for data-processing and STR, 5 for LDR.

Decomposition:
- ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
  - Localparams for alu_control, alu_src_b, result_src, imm_src and cmd encodings.
  - Localparams for cond codes.
- Sub-module cond_unit holds:
  - The flag register, with clk, rst_n and flag_write_nz/flag_write_cv inputs.
  - The combinational cond_ex evaluation.

Test Plan:
- Reset: hold rst_n=0 two cycles, release -> state FETCH; in FETCH ir_write=1, pc_write=1, alu_src_b=10; flags=0000.
- ADD R1,R2,R3: cond=1110, op=00, funct=001000.
  - Sequence FETCH, DECODE, EXECR, ALUWB.
  - reg_write=1 only in ALUWB; alu_control=00 in EXECR.
- LDR: op=01, funct=011001.
  - 5 states; imm_src=01 throughout.
  - adr_src=1 in MEMRD; result_src=01 and reg_write=1 in MEMWB.
- CMP then BEQ:
  - CMP (funct=010101) with alu_flags=0100 -> Z=1 stored; reg_write stays 0 in ALUWB.
  - BEQ (cond=0000, op=10) -> pc_write=1 in BRANCH, imm_src=10.
  - Repeat with alu_flags=0000 -> pc_write=0 in BRANCH.
- STR with cond=0001 (NE) while Z=1 -> mem_write=0 in MEMWR, FSM returns to FETCH.
- Reset mid-instruction: assert rst_n=0 while in MEMRD -> next state FETCH, no reg_write pulse, flags cleared.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath select codes, data-processing commands and condition codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Unlisted commands run as ADD.
    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flag register plus condition-field evaluation against the stored flags.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_write_nz,
    input  logic       flag_write_cv,
    input  logic [3:0] alu_flags,
    input  logic [3:0] cond,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else begin
            if (flag_write_nz) flags[3:2] <= alu_flags[3:2];
            if (flag_write_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: one state per clock, Moore decode of all
// datapath selects and enables, with architectural writes gated by cond_ex.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_control
);

    state_t     state;
    logic       cond_ex;
    logic [3:0] cmd;
    logic       is_cmp;
    logic       in_exec;
    logic       flag_write_nz;
    logic       flag_write_cv;

    assign cmd     = funct[4:1];
    assign is_cmp  = (cmd == CMD_CMP);
    assign in_exec = (state == EXECR) || (state == EXECI);

    // Logical ops leave C and V untouched.
    assign flag_write_nz = in_exec && cond_ex && (funct[0] || is_cmp);
    assign flag_write_cv = flag_write_nz && (cmd != CMD_AND) && (cmd != CMD_ORR);

    cond_unit u_cond (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_write_nz (flag_write_nz),
        .flag_write_cv (flag_write_cv),
        .alu_flags     (alu_flags),
        .cond          (cond),
        .cond_ex       (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR:  state <= ALUWB;
                EXECI:  state <= ALUWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs depend on the stored flags, so ALUWB sees flags set in EXECR/EXECI.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        imm_src     = (op == 2'b11) ? IMM_8 : op;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            MEMADR: alu_src_b = SRCB_IMM;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = cond_ex;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            EXECR: alu_control = cmd_to_alu(cmd);
            EXECI: begin
                alu_src_b   = SRCB_IMM;
                alu_control = cmd_to_alu(cmd);
            end
            ALUWB: begin
                reg_write = cond_ex && !is_cmp;
                pc_write  = cond_ex && !is_cmp && (rd == 4'd15);
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: a cycle model pushes expected state/outputs, a negedge
// monitor pops and compares against the controller.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, alu_control;

    typedef struct {
        string       name;
        state_t      st;
        logic [13:0] outs;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    state_t     m_state;
    logic [3:0] m_flags;
    string      cur_name;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_alu(input logic [3:0] cm);
        case (cm)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
    //  alu_src_b, result_src, imm_src, alu_control}
    function automatic logic [13:0] m_out(input state_t s);
        logic pcw, irw, rw, mw, adr, sa, ce;
        logic [1:0] sb, rs, imm, ac;
        logic [3:0] cm;
        {pcw, irw, rw, mw, adr, sa} = 6'b0;
        sb = 2'b00; rs = 2'b00; ac = 2'b00;
        imm = (op == 2'b11) ? 2'b00 : op;
        ce = m_cond(cond, m_flags);
        cm = funct[4:1];
        case (s)
            FETCH:  begin irw = 1; pcw = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
            DECODE: begin sa = 1; sb = 2'b10; rs = 2'b10; end
            MEMADR: sb = 2'b01;
            MEMRD:  adr = 1;
            MEMWB:  begin rs = 2'b01; rw = ce; end
            MEMWR:  begin adr = 1; mw = ce; end
            EXECR:  ac = m_alu(cm);
            EXECI:  begin sb = 2'b01; ac = m_alu(cm); end
            ALUWB:  begin rw = ce && cm != 4'b1010; pcw = rw && rd == 4'd15; end
            BRANCH: begin sb = 2'b01; rs = 2'b10; pcw = ce; end
            default: ;
        endcase
        if (!rst_n) {pcw, irw, rw, mw} = 4'b0;
        return {pcw, irw, rw, mw, adr, sa, sb, rs, imm, ac};
    endfunction

    task automatic step();
        exp_t e;
        logic [3:0] cm;
        e.name = cur_name;
        e.st   = m_state;
        e.outs = m_out(m_state);
        sb_q.push_back(e);
        @(posedge clk);
        cm = funct[4:1];
        if (!rst_n) begin
            m_state = FETCH;
            m_flags = 4'b0;
        end else begin
            if ((m_state == EXECR || m_state == EXECI) && m_cond(cond, m_flags) &&
                (funct[0] || cm == 4'b1010)) begin
                m_flags[3:2] = alu_flags[3:2];
                if (cm != 4'b0000 && cm != 4'b1100) m_flags[1:0] = alu_flags[1:0];
            end
            case (m_state)
                FETCH:   m_state = DECODE;
                DECODE:  m_state = (op == 2'b01) ? MEMADR :
                                   (op == 2'b10) ? BRANCH :
                                   (op == 2'b11) ? FETCH  :
                                   (funct[5] ? EXECI : EXECR);
                MEMADR:  m_state = funct[0] ? MEMRD : MEMWR;
                MEMRD:   m_state = MEMWB;
                EXECR, EXECI: m_state = ALUWB;
                default: m_state = FETCH;
            endcase
        end
        #1;
    endtask

    task automatic run(input string name, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] af,
                       input int ncyc);
        cur_name = name;
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        repeat (ncyc) step();
        @(negedge clk);
        check({name, "/flags"}, 32'(dut.u_cond.flags), 32'(m_flags));
        check({name, "/back_to_fetch"}, 32'(dut.state), 32'(FETCH));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, "/", e.st.name(), "/state"}, 32'(dut.state), 32'(e.st));
            check({e.name, "/", e.st.name(), "/outs"},
                  32'({pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
                       alu_src_b, result_src, imm_src, alu_control}), 32'(e.outs));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'b0; rd = 4'd0; alu_flags = 4'b0;
        cur_name = "reset";
        m_state = FETCH; m_flags = 4'b0;
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;
        check("reset/flags", 32'(dut.u_cond.flags), 32'h0);

        run("add",      4'hE, 2'b00, 6'b001000, 4'd1,  4'b1111, 4);
        run("ldr",      4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, 5);
        run("cmp_z1",   4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, 4);
        run("beq_take", 4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3);
        run("cmp_z0",   4'hE, 2'b00, 6'b010101, 4'd0,  4'b0000, 4);
        run("beq_skip", 4'h0, 2'b10, 6'b000000, 4'd0,  4'b0100, 3);
        run("cmp_z1b",  4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, 4);
        run("str_ne",   4'h1, 2'b01, 6'b011000, 4'd3,  4'b0000, 4);
        run("addsi_pc", 4'hE, 2'b00, 6'b101001, 4'd15, 4'b0011, 4);
        run("ands_cv",  4'hE, 2'b00, 6'b000001, 4'd4,  4'b1100, 4);
        run("orr_gt",   4'hC, 2'b00, 6'b011000, 4'd5,  4'b0000, 4);
        run("subs_nv",  4'hF, 2'b00, 6'b000101, 4'd6,  4'b0110, 4);
        run("nop",      4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2);

        cur_name = "ldr_rst";
        cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd7; alu_flags = 4'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("ldr_rst/flags", 32'(dut.u_cond.flags), 32'h0);
        check("ldr_rst/state", 32'(dut.state), 32'(FETCH));

        run("beq_after_rst", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 3);
        run("sub_al",        4'hE, 2'b00, 6'b000100, 4'd8, 4'b1111, 4);

        repeat (2) @(negedge clk);
        check("scoreboard/drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
